// File: rtl/sample_irq_sched_if.sv
// CPU-side bus of the sample interrupt scheduler: interrupt request/acknowledge
// handshake plus the sample read port.
interface sample_irq_sched_if #(
  parameter int DATA_W = 16
);
  logic              interrupt_o;
  logic              interrupt_ack_i;
  logic              rd_strobe_i;
  logic [DATA_W-1:0] sample_o;

  modport slave (
    output interrupt_o,
    output sample_o,
    input  interrupt_ack_i,
    input  rd_strobe_i
  );

  modport master (
    input  interrupt_o,
    input  sample_o,
    output interrupt_ack_i,
    output rd_strobe_i
  );
endinterface

// File: rtl/sample_irq_sched.sv
// Sample front-end for PicoBlaze: synchronises data_av_ai, buffers samples in a
// FIFO and hands one sample per interrupt/acknowledge/read cycle to the CPU.
module sample_irq_sched #(
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 8,
  parameter int WINDOW      = 8,
  parameter int ACK_TIMEOUT = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     data_av_ai,
  input  logic [DATA_W-1:0]        data_i,
  sample_irq_sched_if.slave        cpu,
  output logic [$clog2(DEPTH):0]   fifo_level_o,
  output logic                     window_done_o,
  output logic                     overflow_o,
  output logic                     timeout_o,
  input  logic                     clr_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ASSERT, WAIT_RD, HOLDOFF} state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    prev_q;
  logic [DATA_W-1:0]       mem [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]        level_q, level_d;
  logic [DATA_W-1:0]       sample_q, head_d;
  logic [TMR_W-1:0]        timer_q;
  logic [WIN_W-1:0]        win_q;
  logic                    irq_q, done_q, ovf_q, tmo_q;
  logic                    push, pop, full, wr_en, drop, set_timeout;

  // Rising edge of the synchronised level; prev_q resets to 0 so a level that
  // is already high at reset release still produces exactly one push.
  assign push  = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign pop   = (state_q == WAIT_RD) & cpu.rd_strobe_i;
  assign full  = (level_q == LVL_W'(DEPTH));
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // value, which is what turns this chain into a real synchroniser.
      sync_q <= {sync_q[SYNC_STAGES-2:0], data_av_ai};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({wr_en, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    // Bypass the RAM when the word being written becomes the new head.
    head_d = (wr_en && (wr_ptr_q == rd_ptr_d)) ? data_i : mem[rd_ptr_d];
  end

  // NOTE: the sample RAM is deliberately not reset; the level counter alone
  // defines which entries are valid.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      sample_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (level_d != '0) sample_q <= head_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    set_timeout = 1'b0;
    case (state_q)
      IDLE:    if (level_q != '0) state_d = ASSERT;
      ASSERT: begin
        if (cpu.interrupt_ack_i) begin
          state_d = WAIT_RD;
        end else if (timer_q == TMR_W'(ACK_TIMEOUT - 1)) begin
          state_d     = HOLDOFF;
          set_timeout = 1'b1;
        end
      end
      WAIT_RD: if (cpu.rd_strobe_i) state_d = HOLDOFF;
      HOLDOFF: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      irq_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      irq_q   <= (state_d == ASSERT);
      timer_q <= (state_q == ASSERT) ? timer_q + TMR_W'(1) : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      win_q  <= '0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
      tmo_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (pop) begin
        if (win_q == WIN_W'(WINDOW - 1)) begin
          win_q  <= '0;
          done_q <= 1'b1;
        end else begin
          win_q <= win_q + WIN_W'(1);
        end
      end
      // Sticky flags: a new event outranks a simultaneous clear.
      if (drop)             ovf_q <= 1'b1;
      else if (clr_i)       ovf_q <= 1'b0;
      if (set_timeout)      tmo_q <= 1'b1;
      else if (clr_i)       tmo_q <= 1'b0;
    end
  end

  assign cpu.interrupt_o = irq_q;
  assign cpu.sample_o    = sample_q;
  assign fifo_level_o    = level_q;
  assign window_done_o   = done_q;
  assign overflow_o      = ovf_q;
  assign timeout_o       = tmo_q;

endmodule
